// File: rtl/div_arbiter_pkg.sv
// Shared definitions for the round-robin divider arbiter and its shift-subtract engine.
package div_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [31:0] DIV0_Q   = 32'hFFFF_FFFF;
  localparam int          DIV_ITER = 32;

endpackage

// File: rtl/div_engine.sv
// Iterative restoring divider: signed dividend, unsigned divisor, one quotient bit per clock.
module div_engine
  import div_arbiter_pkg::*;
#(
  parameter int DW = 32,
  parameter int VW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [DW-1:0] dividend,
  input  logic        [VW-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic signed [DW-1:0] q
);

  localparam int CW = $clog2(DIV_ITER + 1);

  logic [2*DW-1:0] rq_p0;
  logic [VW-1:0]   dvs_p0;
  logic            neg_p0;
  logic [CW-1:0]   cnt;
  logic [2*DW-1:0] rq_sh;
  logic [2*DW-1:0] rq_nx;

  function automatic logic [DW-1:0] abs_mag(input logic signed [DW-1:0] d);
    logic [DW-1:0] u;
    u = $unsigned(d);
    return d[DW-1] ? (~u + 1'b1) : u;
  endfunction

  function automatic logic signed [DW-1:0] fix_sign(input logic [DW-1:0] mag, input logic neg);
    return neg ? $signed(~mag + 1'b1) : $signed(mag);
  endfunction

  // Upper half holds the partial remainder, lower half shifts dividend bits out and quotient bits in.
  always_comb begin
    rq_sh = rq_p0 << 1;
    rq_nx = rq_sh;
    if (rq_sh[2*DW-1:DW] >= {{(DW-VW){1'b0}}, dvs_p0}) begin
      rq_nx[2*DW-1:DW] = rq_sh[2*DW-1:DW] - {{(DW-VW){1'b0}}, dvs_p0};
      rq_nx[0]         = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq_p0  <= '0;
      dvs_p0 <= '0;
      neg_p0 <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rq_p0  <= {{DW{1'b0}}, abs_mag(dividend)};
        dvs_p0 <= divisor;
        neg_p0 <= dividend[DW-1];
        cnt    <= CW'(DIV_ITER);
        busy   <= 1'b1;
      end else if (busy) begin
        rq_p0 <= rq_nx;
        cnt   <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // Truncation toward zero: divide magnitudes, then restore the dividend's sign.
  assign q = fix_sign(rq_p0[DW-1:0], neg_p0);

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one div_engine among N_REQ req/ack requesters.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = 32,
  parameter int VW    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DW-1:0]        dividend_in,
  input  logic [N_REQ*VW-1:0]        divisor_in,
  output logic [N_REQ-1:0]           ack,
  output logic signed [DW-1:0]       quotient,
  output logic                       div0,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   gnt_id
);

  localparam int IW = $clog2(N_REQ);

  state_t               state;
  state_t               state_nx;
  logic [IW-1:0]        rr;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        sel_id;
  logic                 sel_vld;
  logic signed [DW-1:0] sel_dvd;
  logic [VW-1:0]        sel_dvs;
  logic signed [DW-1:0] dvd_lat;
  logic [VW-1:0]        dvs_lat;
  logic                 eng_start;
  logic                 eng_busy;
  logic                 eng_done;
  logic signed [DW-1:0] eng_q;

  // First pending requester at or after the round-robin pointer, with wrap.
  always_comb begin
    idx     = '0;
    sel_vld = 1'b0;
    sel_id  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = IW'((int'(rr) + i) % N_REQ);
      if (!sel_vld && req[idx]) begin
        sel_vld = 1'b1;
        sel_id  = idx;
      end
    end
  end

  always_comb begin
    sel_dvd = '0;
    sel_dvs = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_id == IW'(i)) begin
        sel_dvd = dividend_in[i*DW +: DW];
        sel_dvs = divisor_in[i*VW +: VW];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (sel_vld) state_nx = LOAD;
      LOAD: state_nx = (dvs_lat == '0) ? RESP : RUN;
      RUN:  if (eng_done && !eng_busy) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= '0;
      gnt_id    <= '0;
      quotient  <= '0;
      div0      <= 1'b0;
      eng_start <= 1'b0;
    end else begin
      state     <= state_nx;
      eng_start <= 1'b0;
      case (state)
        IDLE: if (sel_vld) gnt_id <= sel_id;
        LOAD: begin
          if (dvs_lat == '0) begin
            quotient <= DIV0_Q;
            div0     <= 1'b1;
          end else begin
            eng_start <= 1'b1;
          end
        end
        RUN: begin
          if (eng_done) begin
            quotient <= eng_q;
            div0     <= 1'b0;
          end
        end
        RESP: begin
          if (int'(gnt_id) == N_REQ - 1) rr <= '0;
          else                           rr <= gnt_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Operand latch is pure data; later changes on the request bus are ignored until the next grant.
  always_ff @(posedge clk) begin
    if (state == IDLE && sel_vld) begin
      dvd_lat <= sel_dvd;
      dvs_lat <= sel_dvs;
    end
  end

  assign busy = (state != IDLE);
  assign ack  = (state == RESP) ? (N_REQ'(1) << gnt_id) : '0;

  div_engine #(
    .DW(DW),
    .VW(VW)
  ) u_eng (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (eng_start),
    .dividend (dvd_lat),
    .divisor  (dvs_lat),
    .busy     (eng_busy),
    .done     (eng_done),
    .q        (eng_q)
  );

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter: a timing/arbitration reference model pushes expected acks, a monitor pops them.
module tb_div_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int VW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req = '0;
  logic [N*DW-1:0]   dividend_in = '0;
  logic [N*VW-1:0]   divisor_in = '0;
  logic [N-1:0]      ack;
  logic signed [DW-1:0] quotient;
  logic              div0;
  logic              busy;
  logic [1:0]        gnt_id;

  div_arbiter #(.N_REQ(N), .DW(DW), .VW(VW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .dividend_in (dividend_in),
    .divisor_in  (divisor_in),
    .ack         (ack),
    .quotient    (quotient),
    .div0        (div0),
    .busy        (busy),
    .gnt_id      (gnt_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] q;
    logic        d0;
    longint      ack_e;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     failures = 0;

  // Reference model state: edges counted while out of reset.
  longint      ecnt = 0;
  bit          m_active = 0;
  longint      m_grant_e = 0;
  longint      m_ack_e = 0;
  int          m_rr = 0;
  int          m_id;
  logic [31:0] m_dvd;
  logic [15:0] m_dvs;

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [15:0] b);
    longint sa, sb, r;
    if (b == 16'd0) return 32'hFFFF_FFFF;
    sa = longint'($signed(a));
    sb = longint'({16'h0, b});
    r  = sa / sb;
    return r[31:0];
  endfunction

  // Server free two edges after the previous ack; grant = first pending from rr upward.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0;
      m_rr     = 0;
    end else begin
      ecnt++;
      if ((!m_active || ecnt >= m_ack_e + 2) && req != '0) begin
        m_id = -1;
        for (int k = 0; k < N; k++)
          if (m_id < 0 && req[(m_rr + k) % N]) m_id = (m_rr + k) % N;
        m_dvd = dividend_in[m_id*DW +: DW];
        m_dvs = divisor_in[m_id*VW +: VW];
        m_active  = 1;
        m_grant_e = ecnt;
        m_ack_e   = ecnt + ((m_dvs == 16'd0) ? 1 : 35);
        exp_q.push_back('{m_id, ref_div(m_dvd, m_dvs), (m_dvs == 16'd0), m_ack_e});
        m_rr = (m_id + 1) % N;
      end
    end
  end

  int          rd_idx = 0;
  logic [31:0] last_q = '0;
  logic        last_d0 = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, expv, ecnt);
    end
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_quotient", quotient, 32'd0);
      chk("rst_div0", 32'(div0), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_gnt_id", 32'(gnt_id), 32'd0);
      rd_idx  = exp_q.size();
      last_q  = '0;
      last_d0 = 1'b0;
    end else begin
      chk("busy", 32'(busy), 32'(m_active && ecnt >= m_grant_e && ecnt <= m_ack_e));
      if (rd_idx < exp_q.size() && exp_q[rd_idx].ack_e <= ecnt) begin
        chk("ack", 32'(ack), 32'(1) << exp_q[rd_idx].id);
        chk("quotient", quotient, exp_q[rd_idx].q);
        chk("div0", 32'(div0), 32'(exp_q[rd_idx].d0));
        chk("gnt_id", 32'(gnt_id), 32'(exp_q[rd_idx].id));
        last_q  = exp_q[rd_idx].q;
        last_d0 = exp_q[rd_idx].d0;
        rd_idx++;
      end else begin
        chk("no_ack", 32'(ack), 32'd0);
        chk("quotient_hold", quotient, last_q);
        chk("div0_hold", 32'(div0), 32'(last_d0));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (ack[i]) req[i] = 1'b0;
  endtask

  task automatic issue(input int id, input logic [31:0] dvd, input logic [15:0] dvs);
    tick();
    dividend_in[id*DW +: DW] = dvd;
    divisor_in[id*VW +: VW]  = dvs;
    req[id] = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((req != '0 || rd_idx < exp_q.size() || busy) && n < budget) begin
      tick();
      n++;
    end
    if (req != '0 || rd_idx < exp_q.size() || busy) begin
      $display("FAIL drain_timeout: still active after %0d cycles, required idle", budget);
      $fatal(1, "bench stopped on timeout");
    end
  endtask

  task automatic rand_ops(input int id);
    int r;
    r = int'($urandom_range(0, 9));
    dividend_in[id*DW +: DW] = (r == 0) ? 32'h8000_0000 : $urandom;
    r = int'($urandom_range(0, 9));
    if (r == 0)      divisor_in[id*VW +: VW] = 16'd0;
    else if (r == 1) divisor_in[id*VW +: VW] = 16'd1;
    else if (r < 6)  divisor_in[id*VW +: VW] = 16'($urandom_range(1, 100));
    else             divisor_in[id*VW +: VW] = 16'($urandom_range(1, 65535));
  endtask

  initial begin
    int acks;
    int n;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    issue(1, 32'd1000, 16'd7);          drain(100);
    issue(0, -32'sd1000, 16'd7);        drain(100);
    issue(0, 32'h8000_0000, 16'd1);     drain(100);
    issue(2, 32'd5, 16'd0);             drain(100);

    // All four requesters held; each re-raises one cycle after its ack.
    tick();
    for (int i = 0; i < N; i++) begin
      dividend_in[i*DW +: DW] = 32'(1000 * (i + 1) + 17);
      divisor_in[i*VW +: VW]  = 16'(i + 3);
      req[i] = 1'b1;
    end
    acks = 0;
    n = 0;
    while (acks < 5 && n < 400) begin
      tick();
      n++;
      for (int i = 0; i < N; i++) begin
        if (ack[i]) acks++;
        else if (!req[i] && acks < 5) begin
          rand_ops(i);
          req[i] = 1'b1;
        end
      end
    end
    if (acks < 5) begin
      $display("FAIL rr_timeout: %0d acks seen, required 5", acks);
      $fatal(1, "bench stopped on timeout");
    end
    drain(300);

    // Operands changed after latching, request dropped mid-operation.
    issue(1, 32'd50000, 16'd9);
    repeat (5) tick();
    dividend_in[1*DW +: DW] = 32'd7;
    divisor_in[1*VW +: VW]  = 16'd0;
    repeat (5) tick();
    req[1] = 1'b0;
    drain(100);

    // Reset in the middle of an engine run, then a fresh request.
    issue(3, 32'd500, 16'd7);
    repeat (20) tick();
    #1 rst_n = 1'b0;
    req = '0;
    repeat (2) tick();
    #1 rst_n = 1'b1;
    issue(3, 32'd100, 16'd3);
    drain(100);

    // Random contention with occasional operand churn.
    repeat (2000) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req[i] && !ack[i] && $urandom_range(0, 99) < 4) begin
          rand_ops(i);
          req[i] = 1'b1;
        end else if (req[i] && !ack[i] && $urandom_range(0, 99) < 3) begin
          rand_ops(i);
        end
      end
    end
    drain(400);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one iterative 32/16 shift-subtract divider engine among N_REQ requesters, e.g. the VCU torque, speed and current-scaling paths.
- Round-robin arbitration with a req/ack handshake per requester.
- Latches the granted operands, sequences the engine through start, busy and done, and returns the quotient with an ack pulse.
- Divide-by-zero is handled without using the engine.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 32, dividend and quotient width (signed two's complement).
- VW, 16, divisor width (unsigned).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request level; held until the matching ack.
- dividend_in  in  N_REQ*DW  packed dividends; requester i uses bits [i*DW +: DW].
- divisor_in  in  N_REQ*VW  packed divisors; requester i uses bits [i*VW +: VW].
- ack  out  N_REQ  one-cycle completion pulse, one-hot.
- quotient  out  DW  result of the last completed operation.
- div0  out  1  set when the last completed operation had divisor 0.
- busy  out  1  high whenever state is not IDLE.
- gnt_id  out  $clog2(N_REQ)  index of the requester currently or last served.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; ack, quotient, div0, busy and gnt_id all 0.
  - Round-robin pointer rr=0; engine cleared.
- State machine: IDLE -> LOAD -> RUN -> RESP -> IDLE.
  - IDLE:
    - If req is nonzero, select the first set bit searching from rr upward, with wrap.
    - Latch that requester's dividend and divisor and gnt_id.
    - Go to LOAD.
  - LOAD:
    - If the latched divisor is 0: quotient=32'hFFFF_FFFF, div0=1, go to RESP.
    - Otherwise pulse eng_start for one cycle and go to RUN.
  - RUN: wait for eng_done, then capture eng_q into quotient, set div0=0, go to RESP.
  - RESP:
    - Set ack[gnt_id]=1 for exactly this cycle.
    - Set rr=(gnt_id+1) mod N_REQ.
    - Go to IDLE.
- Engine (div_engine):
  - On start: magnitude a=|dividend| (unsigned 32 bit; 0x8000_0000 is legal), load 64-bit remainder/quotient register.
  - Then 32 shift-compare-subtract iterations, one per clock.
  - Sign correction: result is negated if the dividend was negative; truncation is toward zero.
  - eng_done pulses on the cycle after the last iteration.
  - Engine is start-to-done 33 cycles.
- Latency, counted from the edge that samples req in IDLE (cycle 0):
  - Nonzero divisor: ack high in cycle 36.
  - Zero divisor: ack high in cycle 2.
  - busy is high from cycle 1 through the ack cycle inclusive.
- Back-to-back operation:
  - IDLE may accept a new req in the cycle after RESP.
  - The minimum spacing between acks is 37 cycles.
- Requesters:
  - A requester must drop req in the cycle after its ack, or its held req is treated as a new request.
  - Operand changes after latching are ignored.
  - If req drops during RUN, the operation still completes and ack still pulses.
  - quotient and div0 hold their value until the next RESP.
- Arbitration:
  - Requests arriving while busy are queued implicitly; they are held levels and are evaluated in the next IDLE.
  - If several requests are pending, exactly one is granted per IDLE visit.
  - With all N_REQ requests continuously asserted, the grants follow 0,1,2,3,0…; no requester is starved.
- Reset mid-operation: abort immediately; no ack is issued for the aborted request.
- Result range: -2^31/1 gives 0x8000_0000. Overflow is impossible because the divisor is at least 1.

Decomposition:
- Shared package holds:
  - State encodings: IDLE=2'd0, LOAD=2'd1, RUN=2'd2, RESP=2'd3.
  - DIV0_Q=32'hFFFF_FFFF.
  - DIV_ITER=32.
- One sub-module, div_engine:
  - Ports clk, rst_n, start, dividend[31:0], divisor[15:0], busy, done, q[31:0].
  - Reusable by other blocks that need a handshaked divider.
- Arbiter, FSM and output registers live in div_arbiter.

Test Plan:
- Single request: req[1]=1 with dividend=1000, divisor=7 -> ack[1] in cycle 36, quotient=142, div0=0, gnt_id=1.
- Negative dividend: req[0] with -1000/7 -> quotient=-142 (0xFFFF_FF72); -2147483648/1 -> quotient=0x8000_0000.
- Divide by zero: req[2] with 5/0 -> ack[2] in cycle 2, quotient=0xFFFF_FFFF, div0=1, engine never started.
- Round robin: req=4'b1111 held (each requester drops and reasserts req around its ack) with distinct operands -> ack order 0,1,2,3,0, each quotient correct, acks 37 cycles apart.
- Reset mid-RUN: assert rst_n=0 at cycle 20 of an operation -> all outputs 0 at once, no ack; after release a new req[3] with 100/3 gives 33 in cycle 36.
- Late req drop and operand change: change dividend_in in cycle 5 and drop req in cycle 10 -> the original operands' quotient is still produced and the ack still pulses.
